// File: rtl/axi2sram_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) shared by the SRAM responder and its masters.
interface axi4_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]       aw_id;
    logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                    aw_len;
    logic [2:0]                    aw_size;
    logic [1:0]                    aw_burst;
    logic                          aw_valid;
    logic                          aw_ready;
    logic [AXI_DATA_WIDTH-1:0]     w_data;
    logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
    logic                          w_last;
    logic                          w_valid;
    logic                          w_ready;
    logic [AXI_ID_WIDTH-1:0]       b_id;
    logic [1:0]                    b_resp;
    logic [AXI_USER_WIDTH-1:0]     b_user;
    logic                          b_valid;
    logic                          b_ready;
    logic [AXI_ID_WIDTH-1:0]       ar_id;
    logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                    ar_len;
    logic [2:0]                    ar_size;
    logic [1:0]                    ar_burst;
    logic                          ar_valid;
    logic                          ar_ready;
    logic [AXI_ID_WIDTH-1:0]       r_id;
    logic [AXI_DATA_WIDTH-1:0]     r_data;
    logic [1:0]                    r_resp;
    logic                          r_last;
    logic [AXI_USER_WIDTH-1:0]     r_user;
    logic                          r_valid;
    logic                          r_ready;

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi2sram.sv
// AXI4 slave serving one burst at a time from a single-port synchronous SRAM
// with 1-cycle read latency; read and write requests are granted round-robin.
module axi2sram #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        AXI_USER_WIDTH = 1,
    parameter int                        MEM_DEPTH      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
    localparam int                       DBYTES         = AXI_DATA_WIDTH / 8,
    localparam int                       MAW            = $clog2(MEM_DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    axi4_if.Slave                     AxiIf_S,
    output logic                      o_sram_en,
    output logic [DBYTES-1:0]         o_sram_we,
    output logic [MAW-1:0]            o_sram_addr,
    output logic [AXI_DATA_WIDTH-1:0] o_sram_wdata,
    input  logic [AXI_DATA_WIDTH-1:0] i_sram_rdata,
    output logic [2:0]                o_state
);
    localparam int AW      = AXI_ADDR_WIDTH;
    localparam int LOG2_DB = $clog2(DBYTES);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RWAIT = 3'd4,
        RRESP = 3'd5
    } state_t;

    state_t                    state, state_nx;
    logic                      prio;      // 0: write wins a tie, 1: read wins
    logic [AW-1:0]             addr;
    logic [7:0]                len, cnt;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic                      err;
    logic                      rd_ok;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                r_resp_q;

    logic aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
    logic aw_hs, ar_hs, is_last;
    logic [AW-1:0] offset, word_idx, step, addr_next;
    logic bad_burst, in_range, beat_ok;

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits for ready, ready may follow valid.
    assign aw_hs   = AxiIf_S.aw_valid && aw_rdy;
    assign ar_hs   = AxiIf_S.ar_valid && ar_rdy;
    assign is_last = (cnt == len);

    // Current beat decode; a bad burst errors every beat and never touches the SRAM.
    assign offset    = addr - BASE_ADDR;
    assign word_idx  = offset >> LOG2_DB;
    assign in_range  = (addr >= BASE_ADDR) && (word_idx < AW'(MEM_DEPTH));
    assign bad_burst = (burst == BURST_WRAP) || (size > 3'(LOG2_DB));
    assign beat_ok   = !bad_burst && in_range;
    assign step      = AW'(1) << size;
    assign addr_next = (burst == BURST_FIXED) ? addr : ((addr & ~(step - AW'(1))) + step);

    always_comb begin
        state_nx     = state;
        aw_rdy       = 1'b0;
        ar_rdy       = 1'b0;
        w_rdy        = 1'b0;
        b_vld        = 1'b0;
        r_vld        = 1'b0;
        o_sram_en    = 1'b0;
        o_sram_we    = '0;
        o_sram_addr  = word_idx[MAW-1:0];
        o_sram_wdata = AxiIf_S.w_data;
        case (state)
            IDLE: begin
                aw_rdy = AxiIf_S.aw_valid && (!AxiIf_S.ar_valid || !prio);
                ar_rdy = AxiIf_S.ar_valid && (!AxiIf_S.aw_valid || prio);
                if (aw_rdy)      state_nx = WDATA;
                else if (ar_rdy) state_nx = RREQ;
            end
            WDATA: begin
                w_rdy = 1'b1;
                if (AxiIf_S.w_valid) begin
                    o_sram_en = beat_ok;
                    o_sram_we = beat_ok ? AxiIf_S.w_strb : '0;
                    if (is_last) state_nx = WRESP;
                end
            end
            WRESP: begin
                b_vld = 1'b1;
                if (AxiIf_S.b_ready) state_nx = IDLE;
            end
            RREQ: begin
                o_sram_en = beat_ok;
                state_nx  = RWAIT;
            end
            RWAIT: state_nx = RRESP;
            RRESP: begin
                r_vld = 1'b1;
                if (AxiIf_S.r_ready) state_nx = is_last ? IDLE : RREQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            addr     <= '0;
            len      <= '0;
            cnt      <= '0;
            size     <= '0;
            burst    <= '0;
            id       <= '0;
            err      <= 1'b0;
            rd_ok    <= 1'b0;
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        addr  <= AxiIf_S.aw_addr;
                        len   <= AxiIf_S.aw_len;
                        size  <= AxiIf_S.aw_size;
                        burst <= AxiIf_S.aw_burst;
                        id    <= AxiIf_S.aw_id;
                        cnt   <= '0;
                        err   <= 1'b0;
                        prio  <= 1'b1;
                    end else if (ar_hs) begin
                        addr  <= AxiIf_S.ar_addr;
                        len   <= AxiIf_S.ar_len;
                        size  <= AxiIf_S.ar_size;
                        burst <= AxiIf_S.ar_burst;
                        id    <= AxiIf_S.ar_id;
                        cnt   <= '0;
                        err   <= 1'b0;
                        prio  <= 1'b0;
                    end
                end
                WDATA: begin
                    if (AxiIf_S.w_valid) begin
                        // Misplaced w_last is reported but the burst length still rules.
                        if (!beat_ok || (AxiIf_S.w_last != is_last)) err <= 1'b1;
                        if (!is_last) begin
                            cnt  <= cnt + 8'd1;
                            addr <= addr_next;
                        end
                    end
                end
                RREQ: rd_ok <= beat_ok;
                RWAIT: begin
                    r_data_q <= rd_ok ? i_sram_rdata : '0;
                    r_resp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                end
                RRESP: begin
                    if (AxiIf_S.r_ready && !is_last) begin
                        cnt  <= cnt + 8'd1;
                        addr <= addr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign AxiIf_S.aw_ready = aw_rdy;
    assign AxiIf_S.ar_ready = ar_rdy;
    assign AxiIf_S.w_ready  = w_rdy;
    assign AxiIf_S.b_valid  = b_vld;
    assign AxiIf_S.b_id     = id;
    assign AxiIf_S.b_resp   = err ? RESP_SLVERR : RESP_OKAY;
    assign AxiIf_S.b_user   = '0;
    assign AxiIf_S.r_valid  = r_vld;
    assign AxiIf_S.r_id     = id;
    assign AxiIf_S.r_data   = r_data_q;
    assign AxiIf_S.r_resp   = r_resp_q;
    assign AxiIf_S.r_last   = (state == RRESP) && is_last;
    assign AxiIf_S.r_user   = '0;
    assign o_state          = state;
endmodule

// File: tb/tb_axi2sram.sv
// Bench for axi2sram: a table of bursts against a reference memory, plus sequences
// for arbitration order, R back-pressure and reset during a read response.
module tb_axi2sram;
  localparam int DEPTH = 4096;
  localparam int DB = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2;

  logic i_clk = 1'b0;
  logic i_rst;
  logic sram_en;
  logic [DB-1:0] sram_we;
  logic [11:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic [2:0] dut_state;

  always #5 i_clk = ~i_clk;

  axi4_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi ();

  axi2sram #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .AxiIf_S(axi),
    .o_sram_en(sram_en),
    .o_sram_we(sram_we),
    .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata),
    .i_sram_rdata(sram_rdata),
    .o_state(dut_state)
  );

  // SRAM model and the bench's own reference copy of its contents
  logic [63:0] mem [DEPTH];
  logic [63:0] gold [DEPTH];

  function automatic logic [63:0] init_word(input int i);
    return {32'hC0DE_0000 + 32'(i), ~32'(i)};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = init_word(i);
      gold[i] = init_word(i);
    end
  end

  always @(posedge i_clk) begin
    if (sram_en) begin
      if (sram_we != '0) begin
        for (int b = 0; b < DB; b++)
          if (sram_we[b]) mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [70:0] exp_r_q[$];   // {id, resp, last, data}
  logic [5:0]  exp_b_q[$];   // {id, resp}
  logic [83:0] exp_w_q[$];   // {word, strb, data}
  logic        grant_q[$];   // 1 = write granted, 0 = read granted
  bit rr_steady = 1'b1;
  bit r_in_burst = 1'b0;
  bit holding = 1'b0;
  logic [65:0] held;
  int last_r_cyc = 0;
  logic [70:0] e_r;
  logic [5:0] e_b;
  logic [83:0] e_w;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (i_rst) begin
      holding = 1'b0;
      r_in_burst = 1'b0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) grant_q.push_back(1'b1);
      if (axi.ar_valid && axi.ar_ready) grant_q.push_back(1'b0);
      if (sram_en && sram_we != '0) begin
        if (exp_w_q.size() == 0) fail_now("sram_write_unexpected");
        else begin
          e_w = exp_w_q.pop_front();
          chk("sram_write", 128'({sram_addr, sram_we, sram_wdata}), 128'(e_w));
        end
      end
      if (axi.b_valid && axi.b_ready) begin
        if (exp_b_q.size() == 0) fail_now("b_unexpected");
        else begin
          e_b = exp_b_q.pop_front();
          chk("b_id_resp", 128'({axi.b_id, axi.b_resp}), 128'(e_b));
        end
      end
      if (holding) chk("r_hold_stable", 128'({axi.r_valid, axi.r_resp, axi.r_data}), 128'({1'b1, held}));
      holding = axi.r_valid && !axi.r_ready;
      held = {axi.r_resp, axi.r_data};
      if (axi.r_valid && axi.r_ready) begin
        if (exp_r_q.size() == 0) fail_now("r_unexpected");
        else begin
          e_r = exp_r_q.pop_front();
          chk("r_beat", 128'({axi.r_id, axi.r_resp, axi.r_last, axi.r_data}), 128'(e_r));
        end
        if (rr_steady && r_in_burst) chk("r_beat_spacing", 128'(cyc - last_r_cyc), 128'(3));
        last_r_cyc = cyc;
        r_in_burst = !axi.r_last;
      end
    end
  end

  function automatic logic beat_in(input logic [31:0] a, output logic [11:0] w);
    logic [31:0] off;
    off = a - BASE;
    w = off[14:3];
    return (a >= BASE) && (off[31:3] < 29'(DEPTH));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    step = 32'd1 << size;
    return (burst == FIXED) ? a : ((a & ~(step - 32'd1)) + step);
  endfunction

  // Drivers: each task starts and ends 1 time unit after a rising edge
  task automatic do_write(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [7:0] last_at,
                          input logic [7:0] strb, input logic [63:0] d0);
    logic [31:0] a;
    logic [11:0] w;
    logic bad, err, inr;
    logic [63:0] d;
    int t;
    a = a0;
    err = 1'b0;
    bad = (burst == WRAP) || (size > 3'd3);
    axi.aw_addr = a0; axi.aw_len = len; axi.aw_size = size; axi.aw_burst = burst; axi.aw_id = id;
    axi.aw_valid = 1'b1;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!axi.aw_ready && t < 300);
    if (!axi.aw_ready) begin fail_now("aw_timeout"); axi.aw_valid = 1'b0; return; end
    @(posedge i_clk); #1;
    axi.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = (i == 0) ? d0 : {$urandom, $urandom};
      inr = beat_in(a, w);
      if (!bad && inr) begin
        exp_w_q.push_back({w, strb, d});
        for (int b = 0; b < DB; b++) if (strb[b]) gold[w][b*8 +: 8] = d[b*8 +: 8];
      end else err = 1'b1;
      if ((8'(i) == last_at) != (8'(i) == len)) err = 1'b1;
      axi.w_data = d; axi.w_strb = strb; axi.w_last = (8'(i) == last_at); axi.w_valid = 1'b1;
      t = 0;
      do begin @(negedge i_clk); t++; end while (!axi.w_ready && t < 50);
      if (!axi.w_ready) begin fail_now("w_timeout"); axi.w_valid = 1'b0; return; end
      @(posedge i_clk); #1;
      a = next_addr(a, size, burst);
    end
    axi.w_valid = 1'b0;
    axi.w_last = 1'b0;
    exp_b_q.push_back({id, err ? SLVERR : OKAY});
    @(negedge i_clk);
    chk("b_latency", 128'(axi.b_valid), 128'(1));
    t = 0;
    while (!axi.b_valid && t < 50) begin @(negedge i_clk); t++; end
    if (!axi.b_valid) fail_now("b_timeout");
    @(posedge i_clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic [31:0] a;
    logic [11:0] w;
    logic bad, ok;
    int t, lat;
    a = a0;
    bad = (burst == WRAP) || (size > 3'd3);
    for (int i = 0; i <= int'(len); i++) begin
      ok = beat_in(a, w) && !bad;
      exp_r_q.push_back({id, ok ? OKAY : SLVERR, 8'(i) == len, ok ? gold[w] : 64'd0});
      a = next_addr(a, size, burst);
    end
    axi.ar_addr = a0; axi.ar_len = len; axi.ar_size = size; axi.ar_burst = burst; axi.ar_id = id;
    axi.ar_valid = 1'b1;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!axi.ar_ready && t < 300);
    if (!axi.ar_ready) begin fail_now("ar_timeout"); axi.ar_valid = 1'b0; return; end
    @(posedge i_clk); #1;
    axi.ar_valid = 1'b0;
    lat = 0;
    do begin @(posedge i_clk); lat++; @(negedge i_clk); end while (!axi.r_valid && lat < 50);
    chk("r_first_latency", 128'(lat), 128'(2));
    t = 0;
    while (exp_r_q.size() != 0 && t < 3000) begin @(negedge i_clk); t++; end
    if (exp_r_q.size() != 0) fail_now("r_burst_timeout");
    @(posedge i_clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [7:0]  last_at;
    logic [7:0]  strb;
    logic [63:0] d0;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int t;

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0000, 8'd0,  3'd3, INCR,  4'd3,  8'd0,  8'hFF, 64'h1122_3344_5566_7788};
    vecs[1]  = '{1'b0, 32'h8000_0000, 8'd1,  3'd3, INCR,  4'd5,  8'd0,  8'h00, 64'd0};
    vecs[2]  = '{1'b0, 32'h8000_7FF8, 8'd1,  3'd3, INCR,  4'd6,  8'd0,  8'h00, 64'd0};
    vecs[3]  = '{1'b1, 32'h8000_0100, 8'd3,  3'd3, INCR,  4'd4,  8'd1,  8'hFF, 64'hDEAD_BEEF_0BAD_F00D};
    vecs[4]  = '{1'b0, 32'h8000_0100, 8'd3,  3'd3, INCR,  4'd8,  8'd0,  8'h00, 64'd0};
    vecs[5]  = '{1'b1, 32'h8000_0200, 8'd2,  3'd3, FIXED, 4'd9,  8'd2,  8'h0F, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[6]  = '{1'b0, 32'h8000_0200, 8'd0,  3'd3, FIXED, 4'd10, 8'd0,  8'h00, 64'd0};
    vecs[7]  = '{1'b1, 32'h8000_0300, 8'd1,  3'd3, WRAP,  4'd11, 8'd1,  8'hFF, 64'h1234_5678_9ABC_DEF0};
    vecs[8]  = '{1'b0, 32'h8000_0300, 8'd1,  3'd3, WRAP,  4'd12, 8'd0,  8'h00, 64'd0};
    vecs[9]  = '{1'b0, 32'h8000_0300, 8'd1,  3'd3, INCR,  4'd13, 8'd0,  8'h00, 64'd0};
    vecs[10] = '{1'b1, 32'h7FFF_FFF8, 8'd1,  3'd3, INCR,  4'd14, 8'd1,  8'hFF, 64'h5555_6666_7777_8888};
    vecs[11] = '{1'b0, 32'h7FFF_FFF8, 8'd1,  3'd3, INCR,  4'd15, 8'd0,  8'h00, 64'd0};
    vecs[12] = '{1'b0, 32'h8000_0404, 8'd2,  3'd2, INCR,  4'd1,  8'd0,  8'h00, 64'd0};
    vecs[13] = '{1'b0, 32'h8000_0400, 8'd0,  3'd4, INCR,  4'd2,  8'd0,  8'h00, 64'd0};
    vecs[14] = '{1'b1, 32'h8000_1000, 8'd15, 3'd3, INCR,  4'd3,  8'd15, 8'hA5, 64'h0F0F_0F0F_F0F0_F0F0};
    vecs[15] = '{1'b0, 32'h8000_1000, 8'd15, 3'd3, INCR,  4'd4,  8'd0,  8'h00, 64'd0};
    vecs[16] = '{1'b0, 32'h8000_0504, 8'd1,  3'd3, INCR,  4'd5,  8'd0,  8'h00, 64'd0};

    axi.aw_valid = 1'b0; axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0; axi.aw_burst = '0;
    axi.w_valid = 1'b0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0;
    axi.b_ready = 1'b1;
    axi.ar_valid = 1'b0; axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0; axi.ar_burst = '0;
    axi.r_ready = 1'b1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_outputs", 128'({axi.aw_ready, axi.ar_ready, axi.w_ready, axi.b_valid, axi.r_valid, sram_en, sram_we,
                               axi.b_resp, axi.r_resp, axi.r_last, axi.b_id, axi.r_id, dut_state}), 128'(0));
    chk("reset_r_data", 128'(axi.r_data), 128'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Simultaneous AW+AR right after reset: write first
    grant_q.delete();
    fork
      do_write(32'h8000_0800, 8'd0, 3'd3, INCR, 4'd1, 8'd0, 8'hFF, 64'h0102_0304_0506_0708);
      do_read(32'h8000_0900, 8'd0, 3'd3, INCR, 4'd2);
    join
    chk("arb_round1", 128'({grant_q.size() == 2 ? 2'(grant_q[0]) : 2'd3, grant_q.size() == 2 ? 2'(grant_q[1]) : 2'd3}),
        128'({2'd1, 2'd0}));
    // Leave a lone write in between so the next tie finds read priority
    do_write(32'h8000_0808, 8'd0, 3'd3, INCR, 4'd3, 8'd0, 8'hFF, 64'h1111_2222_3333_4444);
    grant_q.delete();
    fork
      do_write(32'h8000_0810, 8'd0, 3'd3, INCR, 4'd4, 8'd0, 8'hFF, 64'h9999_8888_7777_6666);
      do_read(32'h8000_0808, 8'd0, 3'd3, INCR, 4'd6);
    join
    chk("arb_round2", 128'({grant_q.size() == 2 ? 2'(grant_q[0]) : 2'd3, grant_q.size() == 2 ? 2'(grant_q[1]) : 2'd3}),
        128'({2'd0, 2'd1}));

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id, vecs[i].last_at, vecs[i].strb, vecs[i].d0);
      else
        do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id);
    end

    // Random R back-pressure: data must hold while r_ready is low
    rr_steady = 1'b0;
    fork
      do_read(32'h8000_0100, 8'd5, 3'd3, INCR, 4'd7);
      begin
        repeat (40) begin @(posedge i_clk); #1; axi.r_ready = 1'($urandom_range(0, 1)); end
        axi.r_ready = 1'b1;
      end
    join

    // Reset while a 4-beat read is parked in its first response
    axi.r_ready = 1'b0;
    axi.ar_addr = 32'h8000_0000; axi.ar_len = 8'd3; axi.ar_size = 3'd3; axi.ar_burst = INCR; axi.ar_id = 4'd7;
    axi.ar_valid = 1'b1;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!axi.ar_ready && t < 50);
    if (!axi.ar_ready) fail_now("rst_seq_ar_timeout");
    @(posedge i_clk); #1;
    axi.ar_valid = 1'b0;
    t = 0;
    while (!axi.r_valid && t < 20) begin @(negedge i_clk); t++; end
    if (!axi.r_valid) fail_now("rst_seq_r_valid_timeout");
    chk("stall_first_beat", 128'({axi.r_id, axi.r_resp, axi.r_last, axi.r_data}), 128'({4'd7, OKAY, 1'b0, gold[0]}));
    repeat (2) @(negedge i_clk);
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    chk("rst_r_valid_drop", 128'({axi.r_valid, dut_state}), 128'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    axi.r_ready = 1'b1;
    rr_steady = 1'b1;
    do_read(32'h8000_0008, 8'd0, 3'd3, INCR, 4'd9);

    repeat (3) @(posedge i_clk);
    chk("r_queue_drained", 128'(exp_r_q.size()), 128'(0));
    chk("b_queue_drained", 128'(exp_b_q.size()), 128'(0));
    chk("w_queue_drained", 128'(exp_w_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
